// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory.
// Contents: access size encodings, d_ctrl bit indices, FSM state and owner
// enums, the captured-request payload and a size-to-byte-count helper.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned CTRL_RD = 1;
    localparam int unsigned CTRL_WR = 0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef enum logic {
        INSTR,
        DATA
    } owner_e;

    // Request captured in the grant cycle and held until the response.
    typedef struct packed {
        owner_e              owner;
        logic                rd;
        logic                wr;
        logic [1:0]          size;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic                err;
    } req_t;

    // Number of bytes touched by an access; the illegal encoding maps to 4.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port request arbiter for mem_subsys.
// Ports: en (arbitration allowed this cycle), i_req/d_req (requests),
//        i_gnt_c/d_gnt_c (combinational grants), owner_c (winning port),
//        last_data/last_data_nxt_c (round-robin pointer, current and next).
// Build option MEM_FIXED_PRIO_EN: data port always wins, pointer ports removed.
module mem_arbiter
    import mem_pkg::*;
(
    input  logic   en,
    input  logic   i_req,
    input  logic   d_req,
`ifndef MEM_FIXED_PRIO_EN
    input  logic   last_data,
    output logic   last_data_nxt_c,
`endif
    output logic   i_gnt_c,
    output logic   d_gnt_c,
    output owner_e owner_c
);

    logic pick_data_c;

    // Winner selection; a lone requester always wins.
    always_comb begin
        pick_data_c = 1'b0;
`ifdef MEM_FIXED_PRIO_EN
        pick_data_c = d_req;
`else
        if (d_req && i_req) begin
            pick_data_c = !last_data;
        end else begin
            pick_data_c = d_req;
        end
`endif
        d_gnt_c = en && pick_data_c;
        i_gnt_c = en && i_req && !pick_data_c;
        owner_c = pick_data_c ? DATA : INSTR;
`ifndef MEM_FIXED_PRIO_EN
        last_data_nxt_c = last_data;
        if (d_gnt_c) begin
            last_data_nxt_c = 1'b1;
        end else if (i_gnt_c) begin
            last_data_nxt_c = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/mem_subsys.sv
// Unified byte-addressed memory serving a fetch port and a load/store port
// from one single-ported array, one transaction at a time.
// Ports: clk, reset_n (async active-low); fetch port i_req/i_addr ->
//        i_gnt/i_rvalid/i_rdata/i_err; data port d_req/d_ctrl/d_size/d_addr/
//        d_wdata -> d_gnt/d_rvalid/d_rdata/d_err. Grants are combinational,
//        responses are registered one-cycle strobes.
// Build option MEM_FIXED_PRIO_EN: data port has fixed priority over fetch.
module mem_subsys
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 512,
    parameter int unsigned LATENCY   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic [1:0]        d_ctrl,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err
);

    localparam int unsigned AW    = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    logic [7:0] mem [MEM_BYTES];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d, new_req_c;
    logic              i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
    logic              d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              arb_en_c, i_gnt_c, d_gnt_c, resp_now_c, we_c;
    logic              misalign_c, oor_c;
    logic [2:0]        nbytes_c;
    logic [DATA_W-1:0] rd_word_c;
    owner_e            owner_c;

    assign arb_en_c = (state_q == IDLE);

`ifndef MEM_FIXED_PRIO_EN
    logic last_data_q, last_data_d;

    // Round-robin pointer; reset means "data was served last".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_data_q <= 1'b1;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`endif

    mem_arbiter u_arb (
        .en              (arb_en_c),
        .i_req           (i_req),
        .d_req           (d_req),
`ifndef MEM_FIXED_PRIO_EN
        .last_data       (last_data_q),
        .last_data_nxt_c (last_data_d),
`endif
        .i_gnt_c         (i_gnt_c),
        .d_gnt_c         (d_gnt_c),
        .owner_c         (owner_c)
    );

    // Select the winning port's request and classify it; fetches are word reads.
    always_comb begin
        new_req_c       = '0;
        new_req_c.owner = owner_c;
        if (owner_c == DATA) begin
            new_req_c.rd    = d_ctrl[CTRL_RD];
            new_req_c.wr    = d_ctrl[CTRL_WR];
            new_req_c.size  = d_size;
            new_req_c.addr  = d_addr;
            new_req_c.wdata = d_wdata;
        end else begin
            new_req_c.rd    = 1'b1;
            new_req_c.wr    = 1'b0;
            new_req_c.size  = SZ_WORD;
            new_req_c.addr  = i_addr;
        end
        nbytes_c   = size_bytes(new_req_c.size);
        misalign_c = ((new_req_c.size == SZ_HALF) && new_req_c.addr[0]) ||
                     ((new_req_c.size == SZ_WORD) && (new_req_c.addr[1:0] != 2'b00));
        // 33-bit sum so addresses near 2^32 cannot wrap into range.
        oor_c      = ({1'b0, new_req_c.addr} + 33'(nbytes_c)) > 33'(MEM_BYTES);
        new_req_c.err = (new_req_c.rd == new_req_c.wr) || (new_req_c.size == 2'b11) ||
                        misalign_c || oor_c;
    end

    assign resp_now_c = (state_q == BUSY) && (cnt_q == CNT_LAST);
    assign we_c       = resp_now_c && req_q.wr && !req_q.err;

    // Little-endian read assembly, zero-extended; zero for writes and errors.
    always_comb begin
        rd_word_c = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < size_bytes(req_q.size)) begin
                rd_word_c[8*k +: 8] = mem[AW'(req_q.addr + 32'(k))];
            end
        end
        if (!req_q.rd || req_q.err) begin
            rd_word_c = '0;
        end
    end

    // Storage is not reset; lanes commit on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (we_c) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < size_bytes(req_q.size)) begin
                    mem[AW'(req_q.addr + 32'(k))] <= req_q.wdata[8*k +: 8];
                end
            end
        end
    end

    // Next-state and response logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        i_rvalid_d = 1'b0;
        i_rdata_d  = '0;
        i_err_d    = 1'b0;
        d_rvalid_d = 1'b0;
        d_rdata_d  = '0;
        d_err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_gnt_c || d_gnt_c) begin
                    req_d   = new_req_c;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (resp_now_c) begin
                    state_d = RESP;
                    if (req_q.owner == DATA) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = rd_word_c;
                        d_err_d    = req_q.err;
                    end else begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = rd_word_c;
                        i_err_d    = req_q.err;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            i_err_q    <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            i_rvalid_q <= i_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            i_err_q    <= i_err_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
        end
    end

    assign i_gnt    = i_gnt_c;
    assign d_gnt    = d_gnt_c;
    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign i_err    = i_err_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign d_err    = d_err_q;

endmodule

// File: tb/tb_mem_subsys.sv
// Bench for mem_subsys: a LATENCY=1 instance and a LATENCY=4 instance share
// the stimulus; sel4 routes requests and observation to one of them.
module tb_mem_subsys;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, sel4;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [1:0]  d_ctrl, d_size;

    logic        i_gnt1, i_rvalid1, i_err1, d_gnt1, d_rvalid1, d_err1;
    logic [31:0] i_rdata1, d_rdata1;
    logic        i_gnt4, i_rvalid4, i_err4, d_gnt4, d_rvalid4, d_err4;
    logic [31:0] i_rdata4, d_rdata4;

    logic        i_req1, d_req1, i_req4, d_req4;
    logic        o_i_gnt, o_i_rvalid, o_i_err, o_d_gnt, o_d_rvalid, o_d_err;
    logic [31:0] o_i_rdata, o_d_rdata;

    assign i_req1 = i_req & ~sel4;
    assign d_req1 = d_req & ~sel4;
    assign i_req4 = i_req & sel4;
    assign d_req4 = d_req & sel4;

    assign o_i_gnt    = sel4 ? i_gnt4    : i_gnt1;
    assign o_i_rvalid = sel4 ? i_rvalid4 : i_rvalid1;
    assign o_i_rdata  = sel4 ? i_rdata4  : i_rdata1;
    assign o_i_err    = sel4 ? i_err4    : i_err1;
    assign o_d_gnt    = sel4 ? d_gnt4    : d_gnt1;
    assign o_d_rvalid = sel4 ? d_rvalid4 : d_rvalid1;
    assign o_d_rdata  = sel4 ? d_rdata4  : d_rdata1;
    assign o_d_err    = sel4 ? d_err4    : d_err1;

    mem_subsys #(.MEM_BYTES(512), .LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req1), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1),
        .i_rdata(i_rdata1), .i_err(i_err1),
        .d_req(d_req1), .d_ctrl(d_ctrl), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt1), .d_rvalid(d_rvalid1),
        .d_rdata(d_rdata1), .d_err(d_err1)
    );

    mem_subsys #(.MEM_BYTES(512), .LATENCY(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req4), .i_addr(i_addr), .i_gnt(i_gnt4), .i_rvalid(i_rvalid4),
        .i_rdata(i_rdata4), .i_err(i_err4),
        .d_req(d_req4), .d_ctrl(d_ctrl), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt4), .d_rvalid(d_rvalid4),
        .d_rdata(d_rdata4), .d_err(d_err4)
    );

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mm [512];

    typedef struct {
        bit          is_d;
        logic [1:0]  ctrl;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit is_d, input logic [1:0] ctrl, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.is_d = is_d; v.ctrl = ctrl; v.size = size; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // Reference: legality from the access rules, data from a byte array.
    task automatic model_access(input bit is_d, input logic [1:0] ctrl, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
        logic [1:0] c, s;
        int nb;
        c  = is_d ? ctrl : 2'b10;
        s  = is_d ? size : 2'b10;
        nb = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        err = (c == 2'b00) || (c == 2'b11) || (s == 2'b11) ||
              ((addr % 32'(nb)) != 32'd0) || ((64'(addr) + 64'(nb)) > 64'd512);
        rdata = '0;
        if (!err) begin
            for (int k = 0; k < nb; k++) begin
                if (c == 2'b10) rdata = rdata | (32'(mm[addr + 32'(k)]) << (8 * k));
                else            mm[addr + 32'(k)] = 8'(wdata >> (8 * k));
            end
        end
    endtask

    // One transaction, entered 1ns after a rising edge with the DUT idle.
    // The request is held until the response to expose any stray grant.
    task automatic xact(input string tag, input bit is_d, input logic [1:0] ctrl,
                        input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int  t0, stray, exp_lat;
        bit  got;
        t0 = -1; stray = 0; got = 1'b0; rdata = '0; err = 1'b0;
        exp_lat = sel4 ? 5 : 2;
        if (is_d) begin
            d_req = 1'b1; d_ctrl = ctrl; d_size = size; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int n = 0; n < 10; n++) begin
            #1;
            if (is_d ? o_d_gnt : o_i_gnt) begin
                t0 = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (t0 < 0) begin
            i_req = 1'b0; d_req = 1'b0;
            chk({tag, "_gnt_timeout"}, 32'd0, 32'd1);
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        for (int n = 0; n < 40; n++) begin
            if (o_i_gnt || o_d_gnt) stray++;
            if (is_d ? o_d_rvalid : o_i_rvalid) begin
                chk({tag, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
                rdata = is_d ? o_d_rdata : o_i_rdata;
                err   = is_d ? o_d_err : o_i_err;
                got   = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        i_req = 1'b0; d_req = 1'b0;
        chk({tag, "_rvalid_seen"}, 32'(got), 32'd1);
        chk({tag, "_no_gnt_while_busy"}, 32'(stray), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd, mrd, w;
    logic        er, mer;
    logic [1:0]  g_act, v_act, g_exp, v_exp, own;
    logic [1:0]  c_r, s_r;
    logic [31:0] a_r;
    bit          dport;
    int          nb, r;

    initial begin
        sel4 = 1'b0; reset_n = 1'b1;
        i_req = 1'b1; d_req = 1'b1; i_addr = '0;
        d_ctrl = 2'b10; d_size = 2'b10; d_addr = '0; d_wdata = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Registered outputs in reset.
        chk("rst_i_rvalid", i_rvalid1, 0);
        chk("rst_i_rdata",  i_rdata1,  0);
        chk("rst_i_err",    i_err1,    0);
        chk("rst_d_rvalid", d_rvalid1, 0);
        chk("rst_d_rdata",  d_rdata1,  0);
        chk("rst_d_err",    d_err1,    0);
        chk("rst4_rvalids", {d_rvalid4, i_rvalid4}, 0);

        // Contention from reset: both ports held high.
        reset_n = 1'b1;
        own = 2'b00;
        for (int c = 0; c < 9; c++) begin
            #1;
            g_act = {o_d_gnt, o_i_gnt};
            v_act = {o_d_rvalid, o_i_rvalid};
            g_exp = 2'b00; v_exp = 2'b00;
            if (c % 3 == 0) begin
`ifdef MEM_FIXED_PRIO_EN
                g_exp = 2'b10;
`else
                g_exp = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
`endif
                own = g_exp;
            end
            if (c % 3 == 2) v_exp = own;
            chk($sformatf("contention_gnt_c%0d", c), 32'(g_act), 32'(g_exp));
            chk($sformatf("contention_rvalid_c%0d", c), 32'(v_act), 32'(v_exp));
            if (c == 8) begin i_req = 1'b0; d_req = 1'b0; end
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;

        // Known contents for the whole array.
        for (int a = 0; a < 128; a++) begin
            w = {8'(4*a+3), 8'(4*a+2), 8'(4*a+1), 8'(4*a)} ^ 32'h5A5A_5A5A;
            xact("init", 1'b1, 2'b01, 2'b10, 32'(4*a), w, rd, er);
            model_access(1'b1, 2'b01, 2'b10, 32'(4*a), w, mrd, mer);
            chk("init_err", 32'(er), 32'd0);
        end

        // Directed vectors.
        vt.push_back(mk(1, 2'b01, 2'b10, 32'h40,  32'hDEADBEEF, 32'h0,        0));
        vt.push_back(mk(1, 2'b10, 2'b10, 32'h40,  32'h0,        32'hDEADBEEF, 0));
        vt.push_back(mk(1, 2'b01, 2'b00, 32'h41,  32'hFFFFFFAA, 32'h0,        0));
        vt.push_back(mk(1, 2'b01, 2'b01, 32'h42,  32'hABCD1234, 32'h0,        0));
        vt.push_back(mk(1, 2'b10, 2'b10, 32'h40,  32'h0,        32'h1234AAEF, 0));
        vt.push_back(mk(1, 2'b10, 2'b00, 32'h41,  32'h0,        32'h000000AA, 0));
        vt.push_back(mk(1, 2'b10, 2'b01, 32'h42,  32'h0,        32'h00001234, 0));
        vt.push_back(mk(1, 2'b10, 2'b10, 32'h42,  32'h0,        32'h0,        1));
        vt.push_back(mk(1, 2'b11, 2'b10, 32'h40,  32'h0,        32'h0,        1));
        vt.push_back(mk(1, 2'b10, 2'b10, 32'h40,  32'h0,        32'h1234AAEF, 0));
        vt.push_back(mk(0, 2'b10, 2'b10, 32'h200, 32'h0,        32'h0,        1));
        vt.push_back(mk(0, 2'b10, 2'b10, 32'h40,  32'h0,        32'h1234AAEF, 0));
        vt.push_back(mk(1, 2'b10, 2'b01, 32'h43,  32'h0,        32'h0,        1));
        vt.push_back(mk(1, 2'b10, 2'b11, 32'h40,  32'h0,        32'h0,        1));
        vt.push_back(mk(1, 2'b00, 2'b10, 32'h40,  32'h0,        32'h0,        1));
        vt.push_back(mk(1, 2'b01, 2'b10, 32'h1FC, 32'h11223344, 32'h0,        0));
        vt.push_back(mk(1, 2'b10, 2'b01, 32'h1FE, 32'h0,        32'h00001122, 0));
        vt.push_back(mk(1, 2'b10, 2'b00, 32'h1FF, 32'h0,        32'h00000011, 0));
        vt.push_back(mk(1, 2'b10, 2'b01, 32'h200, 32'h0,        32'h0,        1));
        vt.push_back(mk(1, 2'b01, 2'b00, 32'h200, 32'h77,       32'h0,        1));
        vt.push_back(mk(1, 2'b10, 2'b10, 32'hFFFFFFFC, 32'h0,   32'h0,        1));
        vt.push_back(mk(0, 2'b10, 2'b10, 32'h42,  32'h0,        32'h0,        1));
        vt.push_back(mk(1, 2'b01, 2'b01, 32'h1FF, 32'hFFFF,     32'h0,        1));
        vt.push_back(mk(1, 2'b10, 2'b00, 32'h1FC, 32'h0,        32'h00000044, 0));
        vt.push_back(mk(0, 2'b10, 2'b10, 32'h1FC, 32'h0,        32'h11223344, 0));
        vt.push_back(mk(1, 2'b01, 2'b10, 32'h41,  32'h0,        32'h0,        1));
        vt.push_back(mk(1, 2'b10, 2'b10, 32'h40,  32'h0,        32'h1234AAEF, 0));
        for (int i = 0; i < vt.size(); i++) begin
            xact($sformatf("vec%0d", i), vt[i].is_d, vt[i].ctrl, vt[i].size,
                 vt[i].addr, vt[i].wdata, rd, er);
            model_access(vt[i].is_d, vt[i].ctrl, vt[i].size, vt[i].addr, vt[i].wdata, mrd, mer);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
        end

        // Randomized accesses against the reference model.
        for (int i = 0; i < 300; i++) begin
            dport = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 9));
            c_r = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
            s_r = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            nb  = (s_r == 2'b00) ? 1 : (s_r == 2'b01) ? 2 : 4;
            r = int'($urandom_range(0, 9));
            if (r < 8) begin
                a_r = 32'($urandom_range(0, 511));
                if (r < 6) a_r = a_r & ~32'(nb - 1);
            end else if (r == 8) begin
                a_r = 32'($urandom_range(500, 520));
            end else begin
                a_r = $urandom;
            end
            w = $urandom;
            xact($sformatf("rnd%0d", i), dport, c_r, s_r, a_r, w, rd, er);
            model_access(dport, c_r, s_r, a_r, w, mrd, mer);
            chk($sformatf("rnd%0d_rdata", i), rd, mrd);
            chk($sformatf("rnd%0d_err", i), 32'(er), 32'(mer));
        end

        // Reset while a write is in BUSY: no response, no commit.
        d_req = 1'b1; d_ctrl = 2'b01; d_size = 2'b10; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
        #1;
        chk("rstmid_gnt", 32'(o_d_gnt), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rstmid_rvalid_in_reset", 32'(o_d_rvalid), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rstmid_no_rvalid_c%0d", c), 32'(o_d_rvalid | o_i_rvalid), 32'd0);
            @(posedge clk); #1;
        end
        xact("rstmid_read", 1'b1, 2'b10, 2'b10, 32'h80, 32'h0, rd, er);
        model_access(1'b1, 2'b10, 2'b10, 32'h80, 32'h0, mrd, mer);
        chk("rstmid_old_data", rd, mrd);
        chk("rstmid_err", 32'(er), 32'd0);

        // LATENCY=4 instance.
        sel4 = 1'b1;
        #1;
        xact("lat4_wr", 1'b1, 2'b01, 2'b10, 32'h10, 32'h0BADCAFE, rd, er);
        chk("lat4_wr_err", 32'(er), 32'd0);
        xact("lat4_rd", 1'b1, 2'b10, 2'b10, 32'h10, 32'h0, rd, er);
        chk("lat4_rd_data", rd, 32'h0BADCAFE);
        xact("lat4_bad", 1'b1, 2'b10, 2'b11, 32'h10, 32'h0, rd, er);
        chk("lat4_bad_err", 32'(er), 32'd1);
        chk("lat4_bad_data", rd, 32'h0);
        xact("lat4_fetch", 1'b0, 2'b10, 2'b10, 32'h10, 32'h0, rd, er);
        chk("lat4_fetch_data", rd, 32'h0BADCAFE);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/mem_subsys.md
# mem_subsys

Synthesizable byte-addressed unified memory replacing the behavioural instruction/data memory used around the core. It serves an instruction-fetch port and a load/store data port from one single-ported storage array, with request/grant arbitration, a configurable access latency and byte/half/word sized accesses. Illegal accesses are reported as errors instead of halting simulation. It sits between the core's IF and MEM stages and the storage.

## Interface
- `MEM_BYTES`, default 512: storage size in bytes; must be a multiple of 4.
- `LATENCY`, default 1: cycles from grant to response, 1..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held until `i_gnt`.
- `i_addr`  in  32  fetch byte address; always a word access.
- `i_gnt`  out  1  fetch request accepted this cycle.
- `i_rvalid`  out  1  one-cycle fetch response strobe.
- `i_rdata`  out  32  fetched word; little-endian.
- `i_err`  out  1  fetch error; valid with `i_rvalid`.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_ctrl`  in  2  bit1 = read, bit0 = write.
- `d_size`  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  write data; the low bytes are used for byte and half accesses.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  one-cycle completion strobe; fires for both reads and writes.
- `d_rdata`  out  32  read data, zero-extended; 0 for writes and errors.
- `d_err`  out  1  data error; valid with `d_rvalid`.

## Operation
- **Reset values.** All outputs reset to 0. The FSM goes to IDLE and the round-robin pointer selects "data was last served". Storage contents are not reset.
- **FSM states.**
  - IDLE: when any request is present, grant one requester. `gnt` is combinational from the request and arbiter state, and asserts only in IDLE. The accepted address, control, size and write data are captured, and the FSM moves to BUSY.
  - BUSY: counts `LATENCY-1` further cycles, then moves to RESP.
  - RESP: asserts the owner's `rvalid`, `rdata` and `err` for exactly one cycle, then returns to IDLE.
- **Ordering.** One transaction is outstanding at a time; there is no pipelining.
- **Arbitration.** A single request wins. When both ports request, the port not served last wins (round-robin). The loser keeps its request asserted.
- **Errors.** An error is flagged when any of the following holds:
  - `d_ctrl` = 11 or 00;
  - `d_size` = 11;
  - misalignment: a half access at an odd address, or a word access with `addr[1:0]` ≠ 0;
  - out of range: `addr + bytes > MEM_BYTES`.

  Errored accesses are still granted and still complete with normal latency. They never modify storage and return `rdata` = 0 with `err` = 1. A fetch uses the same alignment and range rules for a word access.
- **Writes.** The addressed bytes are updated at the clock edge entering RESP. Byte lanes are selected by `addr[1:0]` and size; `d_wdata[7:0]` goes to the lowest addressed byte.
- **Reads.** The array is sampled at the edge entering RESP. Byte and half results are placed in `rdata` bits [7:0] and [15:0] with zero upper bits; sign extension is the core's job.
- **Read-after-write.** A read granted after a write has responded returns the new data.
- **Reset mid-transaction.** The transaction is dropped, no write commits and no `rvalid` is issued.

## Timing
- Grant in cycle T (IDLE, request high) → `rvalid` in cycle T+LATENCY+1. With LATENCY = 1: grant at T, `rvalid` at T+2.
- Earliest next grant is T+LATENCY+2, giving a throughput of one access per LATENCY+2 cycles.
- `gnt` never asserts while the FSM is in BUSY or RESP.
- Request inputs are sampled only in the grant cycle; they may change freely after `gnt`.

## Configuration
- **`MEM_FIXED_PRIO_EN` defined:** the data port always wins simultaneous requests. Fetch waits until the data port stops requesting. The round-robin pointer is removed.
- **`MEM_FIXED_PRIO_EN` undefined:** round-robin as described in Operation.

## Structure
- **Package `mem_pkg`:**
  - size encodings: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - `d_ctrl` bit indices: `CTRL_RD` = 1, `CTRL_WR` = 0;
  - FSM state enum: IDLE, BUSY, RESP;
  - owner enum: INSTR, DATA.
- **Sub-module `mem_arbiter`:** two requests in; grant, owner and pointer update out. It contains the `MEM_FIXED_PRIO_EN` selection.
- **Top level:** the storage array, access checker, lane logic and FSM stay in `mem_subsys`.

## Test plan
- Word write then read (LATENCY=1): write 0xDEADBEEF to 0x40, then read 0x40 → write `d_rvalid` at T+2 with `d_err`=0; read `d_rdata` = 0xDEADBEEF.
- Byte and half lanes: write byte 0xAA to 0x41 and half 0x1234 to 0x42, then read word 0x40 → 0x1234AAEF. Read byte at 0x41 → 0x000000AA.
- Contention: `i_req` and `d_req` both held high from reset → grants alternate instr, data, instr. With `MEM_FIXED_PRIO_EN` → data is granted each time it requests.
- Errors:
  - word read at 0x42 → `d_err`=1, `d_rdata`=0;
  - `d_ctrl`=11 → `d_err`=1 and storage unchanged;
  - fetch at 0x200 with MEM_BYTES=512 → `i_err`=1.
- Latency sweep: LATENCY=4 → `rvalid` exactly 5 cycles after `gnt`, and no `gnt` in between.
- Reset mid-write: assert `reset_n`=0 in BUSY → no `rvalid`, and a following read of that address returns the old data.
